// File: rtl/uu_acmac_tx_ba_sb_engine.sv
// uu_acmac_tx_ba_sb_engine: TX block-ack scoreboard update engine.
// Classifies an MPDU SN against its session window and updates the bitmap.
`ifndef UU_SUCCESS
`define UU_SUCCESS 32'h0000_0000
`endif
`ifndef UU_FAILURE
`define UU_FAILURE 32'h0000_0001
`endif
`ifndef UU_BA_SESSION_INVALID
`define UU_BA_SESSION_INVALID 32'h0000_0002
`endif

module uu_acmac_tx_ba_sb_engine #(
  parameter int BUF_DEPTH = 64,
  parameter int SEQ_W     = 12,
  parameter int ADDR_W    = 15,
  parameter int NUM_TID   = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic                       req_val,
  output logic                       req_rdy,
  input  logic [ADDR_W-1:0]          req_sta_offset,
  input  logic [$clog2(NUM_TID)-1:0] req_tid,
  input  logic [15:0]                req_scf,
  output logic                       mem_en,
  output logic [3:0]                 mem_wen,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [31:0]                mem_wdata,
  input  logic [31:0]                mem_rdata,
  output logic                       res_en,
  output logic [31:0]                res_code
);
  localparam int AW    = $clog2(BUF_DEPTH);
  localparam int CW    = AW + 1;
  localparam int REC_W = 2 + BUF_DEPTH / 2;

  typedef enum logic [3:0] {
    S_IDLE, S_RD_H0, S_RD_H1, S_EVAL, S_CLEAR,
    S_RD_BMP, S_SET_BMP, S_WR_H0, S_WR_H1, S_RESP
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [SEQ_W-1:0]  sn_q, sn_d, ws_q, ws_d;
  logic [SEQ_W-1:0]  we_q, we_d, nws_q, nws_d;
  logic [3:0]        fn_q, fn_d;
  logic [AW-1:0]     bws_q, bws_d, idx_q, idx_d;
  logic [AW-1:0]     clr_q, clr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              hit_q, hit_d, adv_q, adv_d;
  logic [31:0]       code_q, code_d;

  logic              act;
  logic [14:0]       wsz;
  logic [SEQ_W-1:0]  d_sn, span, shift;
  logic [AW-1:0]     bws_r, nbws, idx_in, idx_adv;
  logic [AW-1:0]     clr_st, hoff, ent;
  logic [CW-1:0]     nclr;
  logic              sess_ok, in_win, adv;
  logic [ADDR_W-1:0] ent_addr;
  logic [15:0]       half, nhalf;

  assign act     = rst_n & en;
  // HDR1 is on mem_rdata while in EVAL
  assign wsz     = mem_rdata[30:16];
  assign bws_r   = mem_rdata[AW-1:0];
  assign d_sn    = sn_q - ws_q;
  assign span    = we_q - ws_q;
  assign shift   = sn_q - we_q;
  assign sess_ok = mem_rdata[31] && (wsz != 15'd0)
                && (wsz <= 15'(BUF_DEPTH));
  assign in_win  = (d_sn <= span);
  assign adv     = !in_win && !d_sn[SEQ_W-1];
  assign nclr    = (32'(shift) >= 32'(BUF_DEPTH))
                 ? CW'(BUF_DEPTH) : CW'(shift);
  assign nbws    = bws_r + AW'(shift);
  assign idx_in  = bws_r + AW'(d_sn);
  assign idx_adv = nbws + AW'(wsz - 15'd1);
  assign clr_st  = bws_r + AW'(span) + AW'(1);
  assign hoff    = idx_adv - clr_st;

  assign ent      = (state_q == S_CLEAR) ? clr_q : idx_q;
  assign ent_addr = base_q + ADDR_W'(2) + ADDR_W'(ent >> 1);
  // a slot cleared by this request reads as empty
  assign half     = idx_q[0] ? mem_rdata[15:0] : mem_rdata[31:16];
  assign nhalf    = (hit_q ? 16'h0 : half) | (16'h1 << fn_q);

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    sn_d    = sn_q;
    fn_d    = fn_q;
    ws_d    = ws_q;
    we_d    = we_q;
    nws_d   = nws_q;
    bws_d   = bws_q;
    idx_d   = idx_q;
    clr_d   = clr_q;
    cnt_d   = cnt_q;
    hit_d   = hit_q;
    adv_d   = adv_q;
    code_d  = code_q;
    req_rdy   = 1'b0;
    mem_en    = 1'b0;
    mem_wen   = 4'h0;
    mem_addr  = '0;
    mem_wdata = 32'h0;
    res_en    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        req_rdy = 1'b1;
        if (req_val) begin
          state_d = S_RD_H0;
          base_d  = req_sta_offset
                  + ADDR_W'(req_tid) * ADDR_W'(REC_W);
          sn_d    = SEQ_W'(req_scf[15:4]);
          fn_d    = req_scf[3:0];
        end
      end
      S_RD_H0: begin
        mem_en   = 1'b1;
        mem_addr = base_q;
        state_d  = S_RD_H1;
      end
      S_RD_H1: begin
        mem_en   = 1'b1;
        mem_addr = base_q + ADDR_W'(1);
        ws_d     = SEQ_W'(mem_rdata[31:16]);
        we_d     = SEQ_W'(mem_rdata[15:0]);
        state_d  = S_EVAL;
      end
      S_EVAL: begin
        state_d = S_RESP;
        adv_d   = 1'b0;
        hit_d   = 1'b0;
        if (!sess_ok) begin
          code_d = `UU_BA_SESSION_INVALID;
        end else if (in_win) begin
          code_d  = `UU_SUCCESS;
          idx_d   = idx_in;
          state_d = S_RD_BMP;
        end else if (adv) begin
          code_d  = `UU_SUCCESS;
          adv_d   = 1'b1;
          idx_d   = idx_adv;
          bws_d   = nbws;
          nws_d   = sn_q - SEQ_W'(wsz) + SEQ_W'(1);
          clr_d   = clr_st;
          cnt_d   = nclr;
          hit_d   = ({1'b0, hoff} < nclr);
          state_d = (nclr != '0) ? S_CLEAR : S_RD_BMP;
        end else begin
          code_d = `UU_FAILURE;
        end
      end
      S_CLEAR: begin
        mem_en   = 1'b1;
        mem_wen  = clr_q[0] ? 4'h3 : 4'hC;
        mem_addr = ent_addr;
        clr_d    = clr_q + AW'(1);
        cnt_d    = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = S_RD_BMP;
      end
      S_RD_BMP: begin
        mem_en   = 1'b1;
        mem_addr = ent_addr;
        state_d  = S_SET_BMP;
      end
      S_SET_BMP: begin
        mem_en    = 1'b1;
        mem_wen   = idx_q[0] ? 4'h3 : 4'hC;
        mem_addr  = ent_addr;
        mem_wdata = {nhalf, nhalf};
        state_d   = adv_q ? S_WR_H0 : S_RESP;
      end
      S_WR_H0: begin
        mem_en    = 1'b1;
        mem_wen   = 4'hF;
        mem_addr  = base_q;
        mem_wdata = {16'(nws_q), 16'(sn_q)};
        state_d   = S_WR_H1;
      end
      S_WR_H1: begin
        mem_en    = 1'b1;
        mem_wen   = 4'h3;
        mem_addr  = base_q + ADDR_W'(1);
        mem_wdata = 32'(bws_q);
        state_d   = S_RESP;
      end
      S_RESP: begin
        res_en  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (!act) begin
      req_rdy   = 1'b0;
      mem_en    = 1'b0;
      mem_wen   = 4'h0;
      mem_addr  = '0;
      mem_wdata = 32'h0;
      res_en    = 1'b0;
    end
  end

  assign res_code = act ? code_q : `UU_FAILURE;

  always_ff @(posedge clk) begin
    if (!act) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      sn_q    <= '0;
      fn_q    <= '0;
      ws_q    <= '0;
      we_q    <= '0;
      nws_q   <= '0;
      bws_q   <= '0;
      idx_q   <= '0;
      clr_q   <= '0;
      cnt_q   <= '0;
      hit_q   <= 1'b0;
      adv_q   <= 1'b0;
      code_q  <= `UU_FAILURE;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      sn_q    <= sn_d;
      fn_q    <= fn_d;
      ws_q    <= ws_d;
      we_q    <= we_d;
      nws_q   <= nws_d;
      bws_q   <= bws_d;
      idx_q   <= idx_d;
      clr_q   <= clr_d;
      cnt_q   <= cnt_d;
      hit_q   <= hit_d;
      adv_q   <= adv_d;
      code_q  <= code_d;
    end
  end
endmodule

// File: tb/tb_uu_acmac_tx_ba_sb_engine.sv
// tb_uu_acmac_tx_ba_sb_engine: directed bench for the BA scoreboard engine.
// A byte-enabled RAM model holds one session record at a fixed base.
`timescale 1ns/1ps
`ifndef UU_SUCCESS
`define UU_SUCCESS 32'h0000_0000
`endif
`ifndef UU_FAILURE
`define UU_FAILURE 32'h0000_0001
`endif
`ifndef UU_BA_SESSION_INVALID
`define UU_BA_SESSION_INVALID 32'h0000_0002
`endif

module tb_uu_acmac_tx_ba_sb_engine;
  localparam int OFF  = 16;
  localparam int TID  = 2;
  localparam int BASE = 84;

  logic        clk = 1'b0;
  logic        rst_n, en, req_val, req_rdy;
  logic [14:0] req_sta_offset;
  logic [2:0]  req_tid;
  logic [15:0] req_scf;
  logic        mem_en;
  logic [3:0]  mem_wen;
  logic [14:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        res_en;
  logic [31:0] res_code;

  uu_acmac_tx_ba_sb_engine dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .req_val(req_val), .req_rdy(req_rdy),
    .req_sta_offset(req_sta_offset), .req_tid(req_tid),
    .req_scf(req_scf), .mem_en(mem_en), .mem_wen(mem_wen),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .res_en(res_en), .res_code(res_code)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:4095];
  logic        tb_we = 1'b0;
  logic [11:0] tb_a  = '0;
  logic [31:0] tb_d  = '0;

  always @(posedge clk) begin
    if (tb_we) begin
      mem[tb_a] <= tb_d;
    end else if (mem_en) begin
      for (int b = 0; b < 4; b++)
        if (mem_wen[b])
          mem[mem_addr[11:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
      mem_rdata <= mem[mem_addr[11:0]];
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic poke(input int a, input logic [31:0] d);
    @(negedge clk);
    tb_we = 1'b1; tb_a = 12'(a); tb_d = d;
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  task automatic load_rec(input logic [31:0] h0, input logic [31:0] h1,
                          input logic [31:0] fill);
    poke(BASE, h0);
    poke(BASE + 1, h1);
    for (int i = 2; i < 34; i++) poke(BASE + i, fill);
  endtask

  task automatic do_req(input string tag, input logic [15:0] scf,
                        output logic [31:0] code, output int lat,
                        output int nwr);
    bit done;
    done = 1'b0; code = 32'hDEAD_BEEF; lat = 1; nwr = 0;
    @(negedge clk);
    chk({tag, "_rdy_in"}, 32'(req_rdy), 32'd1);
    req_val = 1'b1; req_sta_offset = 15'(OFF);
    req_tid = 3'(TID); req_scf = scf;
    @(negedge clk);
    req_val = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      lat++;
      if (mem_en && mem_wen != 4'h0) nwr++;
      if (res_en) begin
        code = res_code;
        done = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    if (!done) chk({tag, "_timeout"}, 32'd0, 32'd1);
    @(negedge clk);
    chk({tag, "_rdy_out"}, {res_en, 30'd0, req_rdy}, 32'd1);
  endtask

  task automatic abort_at(input string tag, input logic [15:0] scf,
                          input int steps);
    int nres, nmem;
    nres = 0; nmem = 0;
    @(negedge clk);
    req_val = 1'b1; req_sta_offset = 15'(OFF);
    req_tid = 3'(TID); req_scf = scf;
    @(negedge clk);
    req_val = 1'b0;
    repeat (steps) @(negedge clk);
    chk({tag, "_wr_live"}, 32'(mem_wen != 4'h0), 32'd1);
    en = 1'b0;
    #1;
    chk({tag, "_wen_now"}, 32'(mem_wen), 32'd0);
    chk({tag, "_code"}, res_code, `UU_FAILURE);
    @(negedge clk);
    chk({tag, "_quiet"}, {req_rdy, mem_en, res_en}, 32'd0);
    en = 1'b1;
    #1;
    chk({tag, "_rdy"}, 32'(req_rdy), 32'd1);
    repeat (12) begin
      @(negedge clk);
      if (res_en) nres++;
      if (mem_en) nmem++;
    end
    chk({tag, "_nres"}, 32'(nres), 32'd0);
    chk({tag, "_nmem"}, 32'(nmem), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] code, acc;
    int lat, nwr;
    rst_n = 1'b0; en = 1'b1; req_val = 1'b0;
    req_sta_offset = '0; req_tid = '0; req_scf = '0;
    repeat (3) @(negedge clk);
    chk("rst_outs", {req_rdy, mem_en, mem_wen, res_en}, 32'd0);
    chk("rst_addr", {mem_addr, 17'd0} | mem_wdata, 32'd0);
    chk("rst_code", res_code, `UU_FAILURE);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_rdy", 32'(req_rdy), 32'd1);

    // in-window: sn=110 fn=3 -> entry 15, word +9 low half
    load_rec(32'h0064_00A3, 32'h8040_0005, 32'h0);
    poke(BASE + 9, 32'h1234_0000);
    do_req("inw", {12'd110, 4'd3}, code, lat, nwr);
    chk("inw_code", code, `UU_SUCCESS);
    chk("inw_lat", 32'(lat), 32'd7);
    chk("inw_nwr", 32'(nwr), 32'd1);
    chk("inw_ent", mem[BASE + 9], 32'h1234_0008);
    chk("inw_hdr0", mem[BASE], 32'h0064_00A3);

    // edge of window: sn=winend -> entry 4, word +4 high half
    load_rec(32'h0064_00A3, 32'h8040_0005, 32'h0);
    do_req("edge", {12'd163, 4'd0}, code, lat, nwr);
    chk("edge_code", code, `UU_SUCCESS);
    chk("edge_ent", mem[BASE + 4], 32'h0001_0000);
    chk("edge_nwr", 32'(nwr), 32'd1);

    // advance by 3: clear entries 5,6,7; set entry 7
    load_rec(32'h0064_00A3, 32'h8040_0005, 32'h0);
    poke(BASE + 4, 32'hAAAA_5555);
    poke(BASE + 5, 32'h6666_7777);
    do_req("adv", {12'd166, 4'd2}, code, lat, nwr);
    chk("adv_code", code, `UU_SUCCESS);
    chk("adv_lat", 32'(lat), 32'd12);
    chk("adv_nwr", 32'(nwr), 32'd6);
    chk("adv_w4", mem[BASE + 4], 32'hAAAA_0000);
    chk("adv_w5", mem[BASE + 5], 32'h0000_0004);
    chk("adv_hdr0", mem[BASE], 32'h0067_00A6);
    chk("adv_hdr1", mem[BASE + 1], 32'h8040_0008);

    // sequence wrap: ws=4050 we=4095 size=46 bws=10, sn=2
    load_rec(32'h0FD2_0FFF, 32'h802E_000A, 32'h0);
    do_req("wrap", {12'd2, 4'd0}, code, lat, nwr);
    chk("wrap_code", code, `UU_SUCCESS);
    chk("wrap_lat", 32'(lat), 32'd12);
    chk("wrap_hdr0", mem[BASE], 32'h0FD5_0002);
    chk("wrap_hdr1", mem[BASE + 1], 32'h802E_000D);
    chk("wrap_ent", mem[BASE + 31], 32'h0001_0000);

    // big jump: shift=500 clears the whole bitmap
    load_rec(32'h0064_00A3, 32'h8040_0005, 32'hFFFF_FFFF);
    do_req("big", {12'd663, 4'd15}, code, lat, nwr);
    chk("big_code", code, `UU_SUCCESS);
    chk("big_lat", 32'(lat), 32'd73);
    chk("big_nwr", 32'(nwr), 32'd67);
    chk("big_hdr0", mem[BASE], 32'h0258_0297);
    chk("big_hdr1", mem[BASE + 1], 32'h8040_0039);
    chk("big_ent", mem[BASE + 30], 32'h8000_0000);
    acc = 32'h0;
    for (int i = 2; i < 34; i++)
      if (i != 30) acc = acc | mem[BASE + i];
    chk("big_clr", acc, 32'h0);

    // stale: sn = ws - 10, and d exactly half the SN space
    load_rec(32'h0064_00A3, 32'h8040_0005, 32'h0);
    do_req("stale", {12'd90, 4'd1}, code, lat, nwr);
    chk("stale_code", code, `UU_FAILURE);
    chk("stale_lat", 32'(lat), 32'd5);
    chk("stale_nwr", 32'(nwr), 32'd0);
    do_req("half", {12'd2148, 4'd1}, code, lat, nwr);
    chk("half_code", code, `UU_FAILURE);
    chk("half_nwr", 32'(nwr), 32'd0);
    chk("stale_hdr0", mem[BASE], 32'h0064_00A3);

    // invalid sessions: valid=0, winsize=0, winsize=65
    load_rec(32'h0064_00A3, 32'h0040_0005, 32'h0);
    do_req("inv", {12'd110, 4'd1}, code, lat, nwr);
    chk("inv_code", code, `UU_BA_SESSION_INVALID);
    chk("inv_nwr", 32'(nwr), 32'd0);
    poke(BASE + 1, 32'h8000_0005);
    do_req("sz0", {12'd110, 4'd1}, code, lat, nwr);
    chk("sz0_code", code, `UU_BA_SESSION_INVALID);
    poke(BASE + 1, 32'h8041_0005);
    do_req("sz65", {12'd110, 4'd1}, code, lat, nwr);
    chk("sz65_code", code, `UU_BA_SESSION_INVALID);
    chk("sz65_nwr", 32'(nwr), 32'd0);

    // abort while clearing, then while setting the bitmap
    load_rec(32'h0064_00A3, 32'h8040_0005, 32'h0);
    abort_at("ab_clr", {12'd166, 4'd2}, 3);
    chk("ab_clr_hdr0", mem[BASE], 32'h0064_00A3);
    poke(BASE + 9, 32'h1234_0000);
    abort_at("ab_set", {12'd110, 4'd3}, 4);
    chk("ab_set_ent", mem[BASE + 9], 32'h1234_0000);

    // engine still serves requests after an abort
    do_req("post", {12'd110, 4'd3}, code, lat, nwr);
    chk("post_code", code, `UU_SUCCESS);
    chk("post_ent", mem[BASE + 9], 32'h1234_0008);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
